ps2_direction_receiver: RTL

Upstream stage of the snake datapath. It receives PS/2 keyboard frames, oversampling the PS/2 lines on the 50 MHz system clock, and validates each frame. It tracks E0/F0 prefixes and converts arrow-key make codes into the 5-bit one-hot direction word the datapath consumes. It also produces single-cycle event pulses for Enter and Esc and reports framing errors, so the menu/game controller can use keyboard start and abort.

---
 rtl/ps2_direction_receiver.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_receiver.sv
// -----------------------------------------------------------------------------
// ps2_direction_receiver
//
// Front end of the snake datapath. It oversamples the raw PS/2 clock and data
// lines on the system clock and assembles 11-bit frames. Each frame is checked
// for a start bit of 0, a stop bit of 1 and odd parity. Accepted bytes then
// pass through a small E0/F0 prefix tracker. Arrow make codes become a one-hot
// direction word. Enter and Esc make codes become single-cycle event pulses.
//
// Ports
//   clk          in   system clock (CLOCK_50)
//   reset_n      in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock from the keyboard (asynchronous)
//   ps2_dat      in   raw PS/2 data from the keyboard (asynchronous)
//   direction    out  held one-hot direction:
//                       00010 up, 00100 left, 01000 down, 10000 right,
//                       00000 none
//   dir_valid    out  1-cycle pulse whenever direction is written
//                     (same-value rewrites included)
//   start_pulse  out  1-cycle pulse on the Enter make code (0x5A)
//   esc_pulse    out  1-cycle pulse on the Esc make code (0x76)
//   frame_error  out  1-cycle pulse on a rejected frame or an in-frame timeout
//   scan_code    out  last accepted data byte, prefixes included
//   busy         out  high while a frame is being received
//
// Handshake: there is no back-pressure. Every *_pulse / dir_valid /
// frame_error output is high for exactly one clk cycle. The consumer must
// sample it in that cycle. direction and scan_code are held levels that are
// valid whenever the matching pulse is high and that stay stable between
// pulses.
// -----------------------------------------------------------------------------
module ps2_direction_receiver #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [4:0] direction,
   output logic       dir_valid,
   output logic       start_pulse,
   output logic       esc_pulse,
   output logic       frame_error,
   output logic [7:0] scan_code,
   output logic       busy
);

   // A chain shorter than two flops is not a synchroniser, so clamp it.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_UP    = 8'h75;
   localparam logic [7:0] CODE_LEFT  = 8'h6B;
   localparam logic [7:0] CODE_DOWN  = 8'h72;
   localparam logic [7:0] CODE_RIGHT = 8'h74;
   localparam logic [7:0] CODE_ENTER = 8'h5A;
   localparam logic [7:0] CODE_ESC   = 8'h76;

   localparam logic [4:0] DIR_UP    = 5'b00010;
   localparam logic [4:0] DIR_LEFT  = 5'b00100;
   localparam logic [4:0] DIR_DOWN  = 5'b01000;
   localparam logic [4:0] DIR_RIGHT = 5'b10000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchronisers. They are preset to 1 so that reset looks like an idle bus
   // and does not fake a falling edge on release.
   // ---------------------------------------------------------------------------
   logic [SYNC_N-1:0] clk_sync;
   logic [SYNC_N-1:0] dat_sync;
   logic              clk_prev;
   logic              clk_s;
   logic              dat_s;
   logic              fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_N-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_N-2:0], ps2_dat};
         clk_prev <= clk_sync[SYNC_N-1];
      end
   end

   assign clk_s = clk_sync[SYNC_N-1];
   assign dat_s = dat_sync[SYNC_N-1];
   assign fall  = clk_prev & ~clk_s;

   // ---------------------------------------------------------------------------
   // Receiver state.
   // ---------------------------------------------------------------------------
   state_t          state, state_next;
   logic [3:0]      bit_cnt, bit_cnt_next;
   logic [10:0]     frame, frame_next;
   logic [TW-1:0]   tmo, tmo_next;
   logic            ext, ext_next;
   logic            brk, brk_next;

   logic [4:0]      direction_next;
   logic [7:0]      scan_code_next;
   logic            dir_valid_next;
   logic            start_next;
   logic            esc_next;
   logic            error_next;

   // Bits arrive LSB first and are shifted in at the top. After 11 bits:
   // [0] start, [8:1] data, [9] parity, [10] stop.
   logic [7:0]      data_byte;
   logic            frame_ok;

   assign data_byte = frame[8:1];
   assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         frame       <= '0;
         tmo         <= '0;
         ext         <= 1'b0;
         brk         <= 1'b0;
         direction   <= '0;
         scan_code   <= '0;
         dir_valid   <= 1'b0;
         start_pulse <= 1'b0;
         esc_pulse   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         frame       <= frame_next;
         tmo         <= tmo_next;
         ext         <= ext_next;
         brk         <= brk_next;
         direction   <= direction_next;
         scan_code   <= scan_code_next;
         dir_valid   <= dir_valid_next;
         start_pulse <= start_next;
         esc_pulse   <= esc_next;
         frame_error <= error_next;
      end
   end

   always_comb begin
      state_next     = state;
      bit_cnt_next   = bit_cnt;
      frame_next     = frame;
      tmo_next       = tmo;
      ext_next       = ext;
      brk_next       = brk;
      direction_next = direction;
      scan_code_next = scan_code;
      dir_valid_next = 1'b0;
      start_next     = 1'b0;
      esc_next       = 1'b0;
      error_next     = 1'b0;

      case (state)
         IDLE: begin
            tmo_next = '0;
            if (fall) begin
               frame_next   = {dat_s, frame[10:1]};
               bit_cnt_next = 4'd1;
               state_next   = RECV;
            end
         end

         RECV: begin
            if (fall) begin
               frame_next   = {dat_s, frame[10:1]};
               bit_cnt_next = bit_cnt + 4'd1;
               tmo_next     = '0;
               if (bit_cnt == 4'd10) begin
                  state_next = CHECK;
               end
            end else if (tmo == TMO_LAST) begin
               // The keyboard stopped mid-frame. Any prefix seen before this
               // frame can no longer be trusted.
               error_next   = 1'b1;
               bit_cnt_next = '0;
               tmo_next     = '0;
               ext_next     = 1'b0;
               brk_next     = 1'b0;
               state_next   = IDLE;
            end else begin
               tmo_next = tmo + TW'(1);
            end
         end

         CHECK: begin
            // A single cycle. Any edge seen here is a glitch and is dropped.
            state_next   = IDLE;
            bit_cnt_next = '0;
            if (!frame_ok) begin
               error_next = 1'b1;
               ext_next   = 1'b0;
               brk_next   = 1'b0;
            end else begin
               scan_code_next = data_byte;
               if (data_byte == CODE_EXT) begin
                  ext_next = 1'b1;
               end else if (data_byte == CODE_BRK) begin
                  brk_next = 1'b1;
               end else begin
                  // A release (brk set) is swallowed silently. The direction
                  // is held until the next arrow make code.
                  if (!brk) begin
                     case (data_byte)
                        CODE_UP: begin
                           direction_next = DIR_UP;
                           dir_valid_next = 1'b1;
                        end
                        CODE_LEFT: begin
                           direction_next = DIR_LEFT;
                           dir_valid_next = 1'b1;
                        end
                        CODE_DOWN: begin
                           direction_next = DIR_DOWN;
                           dir_valid_next = 1'b1;
                        end
                        CODE_RIGHT: begin
                           direction_next = DIR_RIGHT;
                           dir_valid_next = 1'b1;
                        end
                        CODE_ENTER: start_next = 1'b1;
                        CODE_ESC:   esc_next   = 1'b1;
                        default:    ;
                     endcase
                  end
                  ext_next = 1'b0;
                  brk_next = 1'b0;
               end
            end
         end

         default: begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            tmo_next     = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule
